rd_cmd: RTL and testbench
=========================

# rd_cmd

Serial register-read master for the DDS control port. It shifts an 8-bit read instruction out on SDIO, releases the line, and clocks `DATA_BITS` bits of register contents back in. It presents the result on a parallel `dout` with a one-cycle `done` strobe. It is the read counterpart of `wr_cmd`, shares the same SCLK/CS/SYNCIO pins through the top-level control mux, and drives SDIO through a top-level tri-state buffer.

## Interface
Parameters:
- `CLK_DIV`, default 2: SCLK half-period in `clk` cycles. Legal range is ≥1.
- `DATA_BITS`, default 32: number of bits read back. Legal range is 8..64.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`, input, 1 bit: system clock.
  - `rst`, input, 1 bit: asynchronous, active-high reset.
- Command side:
  - `start`, input, 1 bit: request a read. Sampled only in IDLE.
  - `addr`, input, 8 bits: register address. Captured on an accepted `start`.
  - `dout`, output, `DATA_BITS` bits: read data, MSB first as received. Holds its value until the next `done`.
  - `done`, output, 1 bit: one-cycle strobe; `dout` is valid in that cycle.
  - `busy`, output, 1 bit: high from the cycle after an accepted `start` through the `done` cycle.
- Serial side:
  - `SCLK`, output, 1 bit: serial clock, idle low.
  - `CS`, output, 1 bit: chip select, active low.
  - `SYNCIO`, output, 1 bit: held 0 by this block.
  - `SDIO_OUT`, output, 1 bit: instruction bit to the SDIO buffer.
  - `SDIO_OE`, output, 1 bit: drive-enable for the SDIO buffer.
  - `SDIO_IN`, input, 1 bit: SDIO pin value.

## Operation
- Instruction byte: `{1'b1, addr[6:0]}`. Bit 7 is the read flag and is forced to 1; `addr[7]` is ignored.
- Sent MSB first.
- States:
  - IDLE → SHIFT_INSTR when `start`=1.
  - SHIFT_INSTR → READ after the 8th SCLK falling edge.
  - READ → DONE after the `DATA_BITS`-th SCLK period completes.
  - DONE → IDLE unconditionally after 1 cycle.
- SCLK period is 2·`CLK_DIV` clk cycles:
  - Low phase first, `CLK_DIV` cycles.
  - High phase second, `CLK_DIV` cycles.
  - A divider counter generates the phases. SCLK is a registered output, glitch-free.
- SHIFT_INSTR:
  - `SDIO_OE`=1.
  - `SDIO_OUT` is updated only on SCLK falling transitions. The first bit is presented when CS falls.
  - The slave samples on rising edges.
- READ:
  - `SDIO_OE`=0 from the 8th falling edge onward.
  - `SDIO_IN` is sampled in the clk cycle in which the SCLK register goes 0→1.
  - Each sample is shifted into the LSB of a `DATA_BITS` shift register.
- DONE:
  - `dout` is loaded from the shift register.
  - `done`=1, `CS`=1, `SCLK`=0.
- Bit counter width: ceil(log2(8+`DATA_BITS`+1)). No wrap occurs within a transaction.
- `start` is ignored in SHIFT_INSTR, READ and DONE; it is not queued.
- `start` high in the cycle after DONE begins a new transaction.
- `rst` asserted at any time, including mid-transfer:
  - All outputs return to their reset values immediately.
  - The partial read is discarded and `dout` is cleared.
  - No `done` is generated.

## Timing
- Reset values:
  - `SCLK`=0, `CS`=1, `SYNCIO`=0.
  - `SDIO_OUT`=0, `SDIO_OE`=0.
  - `done`=0, `busy`=0, `dout`=0.
  - State IDLE.
- Cycle numbering: `start` is accepted at clk edge 0.
- Cycles 1 .. 2·`CLK_DIV`·(8+`DATA_BITS`):
  - `CS`=0 and `busy`=1.
  - `SDIO_OE`=1 during the first 16·`CLK_DIV` of these cycles.
- Next cycle (DONE):
  - `CS`=1, `done`=1, `busy`=1, `dout` valid.
- Following cycle: IDLE with `busy`=0.
- Defaults (`CLK_DIV`=2, `DATA_BITS`=32):
  - `CS` low for cycles 1–160.
  - `done` at cycle 161.
  - `SDIO_OE` falls at cycle 33.
- SCLK edges:
  - First rising edge: cycle 1+`CLK_DIV`.
  - Last falling edge: coincides with the start of DONE.
- SCLK rising-edge count per transaction: exactly 8+`DATA_BITS`.

## Test plan
- Reset check: hold `rst`=1, toggle `clk` and `start` → all outputs stay at reset values.
- Read, instruction side: `addr`=0x0E, `start` pulse → SDIO_OUT carries 0x8E on the first 8 rising edges.
- Read, data side: same transaction; the slave model drives 0xDEADBEEF on falling edges → `dout`=0xDEADBEEF with `done` at cycle 161.
- Fastest divider: `CLK_DIV`=1, `DATA_BITS`=16, `addr`=0xFF → instruction 0xFF; 24 SCLK rising edges; `done` at cycle 49; slave data 0xA5C3 → `dout`=0xA5C3.
- Start while busy: a second `start` at cycle 50 of a transaction, and again in the DONE cycle → both ignored, exactly one `done`. A `start` one cycle after DONE → a new transaction with CS low on the next cycle.
- Reset mid-transfer: `rst` pulse at cycle 80 →
  - `CS`=1, `SCLK`=0, `SDIO_OE`=0, `dout`=0 immediately.
  - No `done` follows.
  - A subsequent read of 0x12345678 completes correctly.
- Line release: throughout all of the above, `SDIO_OE`=0 at every sampling edge of the read phase.

Source files
------------

// File: rtl/rd_cmd.sv
// Serial register-read master for the DDS control port: shifts out an 8-bit
// read instruction on SDIO, releases the line, then clocks DATA_BITS back in.
module rd_cmd #(
    parameter int CLK_DIV   = 2,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           addr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 done,
    output logic                 busy,
    output logic                 SCLK,
    output logic                 CS,
    output logic                 SYNCIO,
    output logic                 SDIO_OUT,
    output logic                 SDIO_OE,
    input  logic                 SDIO_IN
);
    localparam int CNT_W = $clog2(8 + DATA_BITS + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] INSTR_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(8 + DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_INSTR, READ, DONE} state_t;

    state_t               state, next;
    logic [DIV_W-1:0]     div_cnt;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 sclk_q;
    logic [7:0]           instr;
    logic [DATA_BITS-1:0] rx;
    logic                 phase_end;
    logic                 fall;

    assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));
    // fall: the SCLK register is about to go 1->0 on this edge
    assign fall      = phase_end && sclk_q;

    assign SCLK     = sclk_q;
    assign SYNCIO   = 1'b0;
    assign SDIO_OUT = (state == SHIFT_INSTR) && instr[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next    = state;
        busy    = 1'b0;
        CS      = 1'b1;
        SDIO_OE = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (start) next = SHIFT_INSTR;
            SHIFT_INSTR: begin
                busy    = 1'b1;
                CS      = 1'b0;
                SDIO_OE = 1'b1;
                if (fall && bit_cnt == INSTR_LAST) next = READ;
            end
            READ: begin
                busy = 1'b1;
                CS   = 1'b0;
                if (fall && bit_cnt == READ_LAST) next = DONE;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk_q  <= 1'b0;
            instr   <= '0;
            rx      <= '0;
            dout    <= '0;
        end else begin
            case (state)
                SHIFT_INSTR, READ: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        sclk_q  <= ~sclk_q;
                        if (sclk_q) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (state == SHIFT_INSTR) instr <= {instr[6:0], 1'b0};
                        end else if (state == READ) begin
                            // sample on the cycle SCLK goes 0->1
                            rx <= {rx[DATA_BITS-2:0], SDIO_IN};
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                    if (state == READ && next == DONE) dout <= rx;
                end
                default: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    sclk_q  <= 1'b0;
                    // read flag forced; addr[7] has no effect
                    if (state == IDLE && start) instr <= addr | 8'h80;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rd_cmd.sv
// Randomized bench for rd_cmd: a slave model serves read data while a
// transaction-level model predicts instruction byte, timing and result.
module tb_rd_cmd;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int          sel;
    logic        start_c;
    logic [7:0]  addr_c;
    logic        sdin_c;

    logic        start0, start1, sdin0, sdin1;
    logic [7:0]  addr0, addr1;
    logic [31:0] dout0;
    logic [15:0] dout1;
    logic done0, busy0, sclk0, cs0, sync0, out0, oe0;
    logic done1, busy1, sclk1, cs1, sync1, out1, oe1;

    assign start0 = (sel == 0) && start_c;
    assign start1 = (sel == 1) && start_c;
    assign addr0  = addr_c;
    assign addr1  = addr_c;
    assign sdin0  = sdin_c;
    assign sdin1  = sdin_c;

    rd_cmd dut0 (.clk(clk), .rst(rst), .start(start0), .addr(addr0), .dout(dout0),
                 .done(done0), .busy(busy0), .SCLK(sclk0), .CS(cs0), .SYNCIO(sync0),
                 .SDIO_OUT(out0), .SDIO_OE(oe0), .SDIO_IN(sdin0));
    rd_cmd #(.CLK_DIV(1), .DATA_BITS(16)) dut1 (.clk(clk), .rst(rst), .start(start1),
                 .addr(addr1), .dout(dout1), .done(done1), .busy(busy1), .SCLK(sclk1),
                 .CS(cs1), .SYNCIO(sync1), .SDIO_OUT(out1), .SDIO_OE(oe1), .SDIO_IN(sdin1));

    logic m_sclk, m_cs, m_oe, m_out, m_done, m_busy, m_sync;
    logic [63:0] m_dout;
    always_comb begin
        m_sclk = sclk0; m_cs = cs0; m_oe = oe0; m_out = out0;
        m_done = done0; m_busy = busy0; m_sync = sync0; m_dout = {32'b0, dout0};
        if (sel == 1) begin
            m_sclk = sclk1; m_cs = cs1; m_oe = oe1; m_out = out1;
            m_done = done1; m_busy = busy1; m_sync = sync1; m_dout = {48'b0, dout1};
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // One full read on the selected instance, called at a negedge. extra_cyc
    // injects a start mid-transfer; start_in_done injects one in the DONE cycle.
    task automatic run_txn(input logic [7:0] a, input logic [63:0] data,
                           input int extra_cyc, input bit start_in_done);
        int cd, db, n;
        int rises = 0, falls = 0, first_rise = -1, done_cyc = -1, ndone = 0;
        int cs_bad = 0, oe_bad = 0;
        logic idle_busy = 1'b1;
        logic [7:0]  instr = 8'h00;
        logic [7:0]  exp_instr;
        logic [63:0] got = 64'h0;
        logic [63:0] d;
        logic prev = 1'b0;
        cd = (sel == 1) ? 1 : 2;
        db = (sel == 1) ? 16 : 32;
        n  = 2 * cd * (8 + db);
        d  = data & ((64'd1 << db) - 64'd1);
        exp_instr = {1'b1, a[6:0]};
        start_c = 1'b1; addr_c = a; sdin_c = 1'($urandom);
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            start_c = (c == extra_cyc) || (start_in_done && c == n + 1);
            addr_c  = 8'($urandom);
            if (m_sclk && !prev) begin
                rises++;
                if (first_rise < 0) first_rise = c;
                if (rises <= 8) instr = {instr[6:0], m_out};
                else if (m_oe) oe_bad++;
            end
            if (!m_sclk && prev) begin
                falls++;
                if (falls >= 8 && falls < 8 + db) sdin_c = d[db - 1 - (falls - 8)];
                else sdin_c = 1'($urandom);
            end else if (falls < 8) begin
                sdin_c = 1'($urandom);
            end
            prev = m_sclk;
            if (c <= n && (m_cs || !m_busy || m_sync)) cs_bad++;
            if (c <= n && m_oe != (c <= 16 * cd)) oe_bad++;
            if (m_done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    got = m_dout;
                    if (!m_busy || !m_cs || m_sclk || m_oe) cs_bad++;
                end
            end
            if (c == n + 2) idle_busy = m_busy;
        end
        n_vec++; if (instr !== exp_instr) begin n_err++; $display("FAIL instr_byte sel=%0d got %h expected %h", sel, instr, exp_instr); end
        n_vec++; if (rises != 8 + db) begin n_err++; $display("FAIL sclk_rises sel=%0d got %0d expected %0d", sel, rises, 8 + db); end
        n_vec++; if (first_rise != 1 + cd) begin n_err++; $display("FAIL first_rise sel=%0d got %0d expected %0d", sel, first_rise, 1 + cd); end
        n_vec++; if (done_cyc != n + 1) begin n_err++; $display("FAIL done_cycle sel=%0d got %0d expected %0d", sel, done_cyc, n + 1); end
        n_vec++; if (ndone != 1) begin n_err++; $display("FAIL done_count sel=%0d got %0d expected 1", sel, ndone); end
        n_vec++; if (got !== d) begin n_err++; $display("FAIL dout sel=%0d got %h expected %h", sel, got, d); end
        n_vec++; if (cs_bad != 0) begin n_err++; $display("FAIL cs_busy_window sel=%0d got %0d bad cycles expected 0", sel, cs_bad); end
        n_vec++; if (oe_bad != 0) begin n_err++; $display("FAIL sdio_oe sel=%0d got %0d bad cycles expected 0", sel, oe_bad); end
        n_vec++; if (idle_busy !== 1'b0) begin n_err++; $display("FAIL busy_after_done sel=%0d got %b expected 0", sel, idle_busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start_c = ~start_c; addr_c = 8'($urandom); sel = i % 2;
            n_vec++;
            if ({sclk0, cs0, sync0, out0, oe0, done0, busy0} !== 7'b0100000 || dout0 !== 32'h0) begin
                n_err++; $display("FAIL reset_dut0 got %b/%h expected 0100000/0", {sclk0, cs0, sync0, out0, oe0, done0, busy0}, dout0);
            end
            n_vec++;
            if ({sclk1, cs1, sync1, out1, oe1, done1, busy1} !== 7'b0100000 || dout1 !== 16'h0) begin
                n_err++; $display("FAIL reset_dut1 got %b/%h expected 0100000/0", {sclk1, cs1, sync1, out1, oe1, done1, busy1}, dout1);
            end
        end
        start_c = 1'b0; sel = 0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        sel = 0; run_txn(8'h0E, 64'hDEADBEEF, -1, 1'b0);
    endtask

    task automatic test_fast();
        sel = 1; run_txn(8'hFF, 64'hA5C3, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 0;
        run_txn(8'($urandom), {32'h0, $urandom}, 50, 1'b1);
        run_txn(8'($urandom), {32'h0, $urandom}, -1, 1'b0);
        sel = 1;
        run_txn(8'($urandom), {32'h0, $urandom}, 20, 1'b1);
        run_txn(8'($urandom), {32'h0, $urandom}, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        sel = 0;
        start_c = 1'b1; addr_c = 8'h33;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start_c = 1'b0; sdin_c = 1'($urandom);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({cs0, sclk0, oe0, done0, busy0} !== 5'b10000 || dout0 !== 32'h0) begin
            n_err++; $display("FAIL reset_mid got cs/sclk/oe/done/busy=%b dout=%h expected 10000/0", {cs0, sclk0, oe0, done0, busy0}, dout0);
        end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done0 || !cs0) stray++;
        end
        n_vec++;
        if (stray != 0) begin n_err++; $display("FAIL no_done_after_reset got %0d active cycles expected 0", stray); end
        run_txn(8'h21, 64'h12345678, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            sel = int'($urandom_range(0, 1));
            run_txn(8'($urandom), {$urandom, $urandom}, -1, 1'b0);
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start_c = 1'b0; addr_c = 8'h00; sdin_c = 1'b0; sel = 0;
        test_reset();
        test_basic();
        test_fast();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
